de3_char_rx: RTL and testbench

Serial character receiver for the DE3 board. It deserialises an asynchronous 8N1 UART line (optionally 8E1) and produces the `char` / `char_valid` pair consumed by the DE3 seven-segment display block. The block sits between the board's RS-232 input pin and the display/console path. It presents each correctly framed character as a 7-bit code with a single-cycle valid strobe.

---
 rtl/de3_pkg.sv | 18 +
 rtl/de3_bit_timer.sv | 34 +++
 rtl/de3_char_rx.sv | 143 ++++++++++++++
 tb/tb_de3_char_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/de3_pkg.sv
// Shared types and constants for the DE3 serial character receiver.
// The PARITY state exists only when DE3_RX_PARITY_EN is defined.
package de3_pkg;

  localparam int CHAR_W    = 7;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef DE3_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/de3_bit_timer.sv
// Bit-period counter: pulses tick once per full bit (or half bit when half=1).
// restart holds the count at zero so the next period starts cleanly.
module de3_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LIM_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LIM_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_limit;

  assign w_limit = half ? LIM_HALF : LIM_FULL;
  assign tick    = ~restart & (r_cnt == w_limit);

  // The count wraps to zero on expiry, so consecutive periods chain with no gap.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/de3_char_rx.sv
// DE3 serial character receiver: 8N1 UART line in, 7-bit char + valid strobe out.
// Define DE3_RX_PARITY_EN for 8E1 framing with even-parity checking.
module de3_char_rx
  import de3_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [CHAR_W-1:0] char,
  output logic              char_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("de3_char_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  logic                 r_rx_m;
  logic                 r_rx_s;
  logic                 r_rx_d;
  logic                 w_fall;
  logic                 w_tick;
  rx_state_t            r_state;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_bad;
  logic [CHAR_W-1:0]    r_char;
  logic                 r_char_valid;
  logic                 r_frame_err;

  // Synchroniser plus one extra stage for edge detection; all idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;

  de3_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (r_state == ST_IDLE),
    .half    (r_state == ST_START),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_idx    <= '0;
      r_shreg      <= '0;
      r_par_bad    <= 1'b0;
      r_char       <= '0;
      r_char_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            // A line that is high again at mid start bit was only a glitch.
            if (r_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_bit_idx <= '0;
              r_par_bad <= 1'b0;
              r_state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
            if (r_bit_idx == LAST_IDX) begin
`ifdef DE3_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
`ifdef DE3_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_par_bad <= r_rx_s ^ (^r_shreg);
            r_state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_rx_s && !r_par_bad) begin
              r_char       <= r_shreg[CHAR_W-1:0];
              r_char_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign char       = r_char;
  assign char_valid = r_char_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_de3_char_rx.sv
// Self-checking bench for de3_char_rx at 16 clocks per bit.
// Define DE3_RX_PARITY_EN to exercise the 8E1 build.
module tb_de3_char_rx;
  import de3_pkg::*;

  localparam int CPB = 16;
`ifdef DE3_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_CLKS = CPB * (10 + PAR_BITS);
  localparam int BUSY_CLKS  = CPB / 2 + CPB * (9 + PAR_BITS);

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       par_flip;
    logic       exp_valid;
    logic       exp_err;
    logic [6:0] exp_char;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [6:0] char;
  logic       char_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  int busy_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  logic [6:0] exp_q[$];
  int vld_cyc_q[$];
  vec_t vecs[$];

  de3_char_rx #(
    .CLK_FREQ (16),
    .BAUD     (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .char       (char),
    .char_valid (char_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cyc++;
    if (char_valid) begin
      vld_cnt++;
      vld_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got char_valid with char 0x%0h, expected no strobe", char);
      end else begin
        check("sb_char", char, exp_q.pop_front());
      end
      check("busy_at_valid", busy, 1'b0);
    end
    if (frame_err) begin
      err_cnt++;
      check("busy_at_err", busy, 1'b0);
    end
    if (char_valid || frame_err) check("strobe_excl", char_valid & frame_err, 1'b0);
    if (prev_valid) check("valid_width", char_valid, 1'b0);
    if (prev_err) check("err_width", frame_err, 1'b0);
    prev_valid = char_valid;
    prev_err   = frame_err;
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef DE3_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop_bit);
  endtask

  initial begin
    int v0, e0, b0, k;

    //               data   stop  pflip valid err  char
    vecs.push_back('{8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 7'h41});
    vecs.push_back('{8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 7'h41});
    vecs.push_back('{8'hD5, 1'b1, 1'b0, 1'b1, 1'b0, 7'h55});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00});
`ifdef DE3_RX_PARITY_EN
    vecs.push_back('{8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 7'h41});
    vecs.push_back('{8'h41, 1'b1, 1'b1, 1'b0, 1'b1, 7'h41});
`endif
    vecs.push_back('{8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 7'h7F});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 7'h7F});

    reset = 1'b1;
    rx    = 1'b1;
    idle(4);
    check("rst_char", char, 7'h00);
    check("rst_valid", char_valid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    idle(4);
    check("post_rst_busy", busy, 1'b0);

    // Table-driven frames
    foreach (vecs[i]) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      b0 = busy_cyc;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_char);
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip);
      rx = 1'b1;
      idle(8);
      check($sformatf("v%0d_valid_cnt", i), vld_cnt - v0, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_err_cnt", i), err_cnt - e0, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_char", i), char, vecs[i].exp_char);
      check($sformatf("v%0d_busy_clks", i), busy_cyc - b0, BUSY_CLKS);
    end

    // Glitch: short low pulse on idle line
    v0 = vld_cnt;
    e0 = err_cnt;
    b0 = busy_cyc;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    k  = 0;
    while (busy !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_clear", busy, 1'b0);
    idle(20);
    check("glitch_busy_clks", busy_cyc - b0, CPB / 2);
    check("glitch_no_valid", vld_cnt - v0, 0);
    check("glitch_no_err", err_cnt - e0, 0);

    // Back-to-back frames, no idle gap
    v0 = vld_cnt;
    vld_cyc_q.delete();
    exp_q.push_back(7'h30);
    exp_q.push_back(7'h31);
    exp_q.push_back(7'h7F);
    send_frame(8'h30, 1'b1, 1'b0);
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h7F, 1'b1, 1'b0);
    idle(8);
    check("b2b_valid_cnt", vld_cnt - v0, 3);
    if (vld_cyc_q.size() == 3) begin
      check("b2b_gap0", vld_cyc_q[1] - vld_cyc_q[0], FRAME_CLKS);
      check("b2b_gap1", vld_cyc_q[2] - vld_cyc_q[1], FRAME_CLKS);
    end
    check("b2b_char", char, 7'h7F);

    // Reset during data bit 3 of 0x55
    v0 = vld_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    idle(8);
    check("mid_busy_before_rst", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    idle(2);
    check("mid_rst_char", char, 7'h00);
    check("mid_rst_valid", char_valid, 1'b0);
    check("mid_rst_err", frame_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    idle(1);
    reset = 1'b0;
    idle(24);
    check("mid_no_valid", vld_cnt - v0, 0);
    check("mid_no_err", err_cnt - e0, 0);
    check("mid_char_held", char, 7'h00);
    exp_q.push_back(7'h2A);
    send_frame(8'h2A, 1'b1, 1'b0);
    idle(8);
    check("after_rst_valid_cnt", vld_cnt - v0, 1);
    check("after_rst_char", char, 7'h2A);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
